frame_buffer_wr_ctrl: RTL

- Sequences the stream-to-AXI4 line writer for video frame buffering.
- Gates the incoming video stream line by line and supplies the per-line byte count and destination address.
- Rotates frames across N_BUFS buffers, never writing the buffer the reader holds.
- Publishes a completed buffer index only after every write burst of the frame has returned its B response.

---
 rtl/frame_buffer_wr_ctrl_if.sv | 23 ++
 rtl/frame_buffer_wr_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_wr_ctrl_if.sv
// AXI4-Stream bundle shared by the frame buffer write path.
// Master drives data and valid, slave drives tready.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tuser;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata, tstrb, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/frame_buffer_wr_ctrl.sv
// Frame sequencer for the stream-to-AXI4 line writer: gates video per line, drives line address and size.
// Latency: SOF to first forwarded beat is 2 cycles; backpressure from video_o passes straight to video_i in PASS_S.
module frame_buffer_wr_ctrl #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          PKT_SIZE_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] FRAME_SIZE_B   = 32'h0080_0000,
    parameter int          LINE_STRIDE_B  = 4096,
    parameter int          LINES_WIDTH    = 12,
    parameter int          N_BUFS         = 3,
    parameter int          OUTST_WIDTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [PKT_SIZE_WIDTH-1:0] line_size_i,
    input  logic [LINES_WIDTH-1:0]    frame_lines_i,
    input  logic [1:0]                rd_buf_i,
    axi4_stream_if.slave              video_i,
    axi4_stream_if.master             video_o,
    output logic [PKT_SIZE_WIDTH-1:0] pkt_size_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    input  logic                      aw_hs_i,
    input  logic                      b_hs_i,
    output logic [1:0]                wr_buf_o,
    output logic                      frame_done_o,
    output logic                      short_frame_o
);

    typedef enum logic [2:0] {
        IDLE_S,
        SETUP_S,
        PASS_S,
        GAP_S,
        DRAIN_S
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                cur_buf_q, cur_buf_d;
    logic [1:0]                wr_buf_q, wr_buf_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [PKT_SIZE_WIDTH-1:0] pkt_q, pkt_d;
    logic [LINES_WIDTH-1:0]    lines_q, lines_d;
    logic [LINES_WIDTH-1:0]    line_cnt_q, line_cnt_d;
    logic [LINES_WIDTH-1:0]    line_cnt_inc;
    logic [OUTST_WIDTH-1:0]    outst_q, outst_d;
    logic                      done_q, done_d;
    logic                      short_q, short_d;
    logic                      in_rdy;
    logic                      pass;

    logic [1:0]            nb_inc, nb_skip, nb_sel;
    logic [ADDR_WIDTH-1:0] buf_base;

    // Next buffer in rotation, stepping over the one the reader holds.
    always_comb begin
        nb_inc   = (cur_buf_q == 2'(N_BUFS - 1)) ? 2'd0 : cur_buf_q + 2'd1;
        nb_skip  = (nb_inc == 2'(N_BUFS - 1)) ? 2'd0 : nb_inc + 2'd1;
        nb_sel   = (nb_inc == rd_buf_i) ? nb_skip : nb_inc;
        buf_base = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(nb_sel) * ADDR_WIDTH'(FRAME_SIZE_B);
    end

    assign line_cnt_inc = line_cnt_q + LINES_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        cur_buf_d  = cur_buf_q;
        wr_buf_d   = wr_buf_q;
        addr_d     = addr_q;
        pkt_d      = pkt_q;
        lines_d    = lines_q;
        line_cnt_d = line_cnt_q;
        done_d     = 1'b0;
        short_d    = 1'b0;
        in_rdy     = 1'b0;
        case (state_q)
            IDLE_S: begin
                // The SOF beat is held, not consumed, so it becomes the first beat of the frame.
                if (video_i.tvalid && video_i.tuser && en_i) begin
                    state_d = SETUP_S;
                end else begin
                    in_rdy = 1'b1;
                end
            end
            SETUP_S: begin
                cur_buf_d  = nb_sel;
                addr_d     = buf_base;
                pkt_d      = line_size_i;
                lines_d    = frame_lines_i;
                line_cnt_d = '0;
                state_d    = PASS_S;
            end
            PASS_S: begin
                in_rdy = video_o.tready;
                if (video_i.tvalid && video_o.tready && video_i.tlast) begin
                    line_cnt_d = line_cnt_inc;
                    addr_d     = addr_q + ADDR_WIDTH'(LINE_STRIDE_B);
                    state_d    = (line_cnt_inc == lines_q) ? DRAIN_S : GAP_S;
                end
            end
            GAP_S: begin
                if (video_i.tvalid) begin
                    if (video_i.tuser) begin
                        short_d = 1'b1;
                        state_d = SETUP_S;
                    end else begin
                        state_d = PASS_S;
                    end
                end
            end
            DRAIN_S: begin
                if (outst_q == '0 && !aw_hs_i) begin
                    wr_buf_d = cur_buf_q;
                    done_d   = 1'b1;
                    state_d  = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({aw_hs_i, b_hs_i})
            2'b10:   outst_d = outst_q + OUTST_WIDTH'(1);
            2'b01:   outst_d = outst_q - OUTST_WIDTH'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE_S;
            cur_buf_q  <= '0;
            wr_buf_q   <= '0;
            addr_q     <= '0;
            pkt_q      <= '0;
            lines_q    <= '0;
            line_cnt_q <= '0;
            outst_q    <= '0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_buf_q  <= cur_buf_d;
            wr_buf_q   <= wr_buf_d;
            addr_q     <= addr_d;
            pkt_q      <= pkt_d;
            lines_q    <= lines_d;
            line_cnt_q <= line_cnt_d;
            outst_q    <= outst_d;
            done_q     <= done_d;
            short_q    <= short_d;
        end
    end

    // Stream is gated combinationally from state so tvalid drops as soon as reset hits.
    assign pass           = (state_q == PASS_S);
    assign video_i.tready = in_rdy;
    assign video_o.tvalid = pass & video_i.tvalid;
    assign video_o.tdata  = pass ? video_i.tdata : '0;
    assign video_o.tstrb  = pass ? video_i.tstrb : '0;
    assign video_o.tkeep  = pass ? video_i.tkeep : '0;
    assign video_o.tlast  = pass & video_i.tlast;
    assign video_o.tuser  = pass & video_i.tuser;

    assign pkt_size_o    = pkt_q;
    assign addr_o        = addr_q;
    assign wr_buf_o      = wr_buf_q;
    assign frame_done_o  = done_q;
    assign short_frame_o = short_q;

    a_outst_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(aw_hs_i && !b_hs_i && (&outst_q)));
    a_outst_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs_i && !aw_hs_i && (outst_q == '0)));

endmodule
